// File: rtl/traffic_sensor_cond_if.sv
// Sensor-conditioning bus: raw loop inputs and controller greens in,
// debounced levels and latched service requests out.
interface traffic_sensor_cond_if;
  logic raw_a;
  logic raw_b;
  logic ga;
  logic gb;
  logic det_a;
  logic det_b;
  logic sa;
  logic sb;

  // The environment drives the road loops and the greens
  modport master (
    output raw_a, raw_b, ga, gb,
    input  det_a, det_b, sa, sb
  );

  // The conditioning stage consumes loops and greens, produces requests
  modport slave (
    input  raw_a, raw_b, ga, gb,
    output det_a, det_b, sa, sb
  );
endinterface

// File: rtl/traffic_sensor_cond.sv
// Vehicle-sensor conditioning ahead of the traffic-light controller.
// Each road channel synchronises its raw loop input through two flops,
// accepts a new level only after it has held for DB_CYCLES consecutive
// synchronised cycles, and latches the debounced detection as a service
// request that stays up until the controller grants green to that road.
// Channels A and B share no state. All outputs come straight from flops.
module traffic_sensor_cond #(
  parameter int DB_CYCLES = 4,
  parameter int CW        = 3
) (
  input logic                  clk,
  input logic                  rst_n,
  traffic_sensor_cond_if.slave bus
);

  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic [1:0] raw;
  logic [1:0] grant;
  logic [1:0] det;
  logic [1:0] req;

  assign raw   = {bus.raw_b, bus.raw_a};
  assign grant = {bus.gb, bus.ga};

  for (genvar ch = 0; ch < 2; ch++) begin : g_chan
    logic          s1;
    logic          s2;
    logic          det_r;
    logic          req_r;
    logic [CW-1:0] cnt;

    // Two-flop synchroniser; the raw loop input is used nowhere else
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1 <= 1'b0;
        s2 <= 1'b0;
      end else begin
        s1 <= raw[ch];
        s2 <= s1;
      end
    end

    // Debounce: count cycles of disagreement, accept the new level on the last one
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        det_r <= 1'b0;
        cnt   <= '0;
      end else if (s2 == det_r) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        det_r <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end

    // Request latch: a green clears it and wins over a detection in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        req_r <= 1'b0;
      end else if (grant[ch]) begin
        req_r <= 1'b0;
      end else begin
        req_r <= req_r | det_r;
      end
    end

    assign det[ch] = det_r;
    assign req[ch] = req_r;
  end

  assign bus.det_a = det[0];
  assign bus.det_b = det[1];
  assign bus.sa    = req[0];
  assign bus.sb    = req[1];

endmodule

// File: tb/tb_traffic_sensor_cond.sv
// Directed bench for traffic_sensor_cond: default-parameter instance for
// most scenarios, plus a DB_CYCLES=1 instance for the short-window case.
module tb_traffic_sensor_cond;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  traffic_sensor_cond_if bus0 ();
  traffic_sensor_cond_if bus1 ();

  traffic_sensor_cond #(.DB_CYCLES(4), .CW(3)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  traffic_sensor_cond #(.DB_CYCLES(1), .CW(3)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  // Free-running 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic obs, input logic exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %b, want %b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic ra, input logic rb, input logic g_a, input logic g_b);
    bus0.raw_a = ra;
    bus0.raw_b = rb;
    bus0.ga    = g_a;
    bus0.gb    = g_b;
  endtask

  // Advance n rising edges, leaving time just after the last one
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    bus1.raw_a = 1'b0;
    bus1.raw_b = 1'b0;
    bus1.ga    = 1'b0;
    bus1.gb    = 1'b0;

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_det_a", bus0.det_a, 1'b0);
    checkOutput("rst_det_b", bus0.det_b, 1'b0);
    checkOutput("rst_sa", bus0.sa, 1'b0);
    checkOutput("rst_sb", bus0.sb, 1'b0);
    checkOutput("rst_sa1", bus1.sa, 1'b0);
    tick(2);
    rst_n = 1'b1;
    tick(2);

    // Clean press on A
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    for (int e = 1; e <= 7; e++) begin
      tick(1);
      if (e == 5) checkOutput("press_det_a_e5", bus0.det_a, 1'b0);
      if (e == 6) begin
        checkOutput("press_det_a_e6", bus0.det_a, 1'b1);
        checkOutput("press_sa_e6", bus0.sa, 1'b0);
      end
      if (e == 7) checkOutput("press_sa_e7", bus0.sa, 1'b1);
      checkOutput("press_det_b", bus0.det_b, 1'b0);
      checkOutput("press_sb", bus0.sb, 1'b0);
    end

    // Release on A: same debounce latency, request held
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    for (int e = 1; e <= 6; e++) begin
      tick(1);
      if (e == 5) checkOutput("rel_det_a_e5", bus0.det_a, 1'b1);
      if (e == 6) checkOutput("rel_det_a_e6", bus0.det_a, 1'b0);
      checkOutput("rel_sa_held", bus0.sa, 1'b1);
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    tick(1);
    checkOutput("grant_sa_clr", bus0.sa, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    tick(3);
    checkOutput("grant_sa_stays", bus0.sa, 1'b0);

    // Clear priority: green held over a steady detection
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    tick(8);
    checkOutput("prio_sa_set", bus0.sa, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    for (int e = 1; e <= 5; e++) begin
      tick(1);
      checkOutput("prio_sa_low", bus0.sa, 1'b0);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    tick(1);
    checkOutput("prio_sa_reassert", bus0.sa, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    tick(6);
    checkOutput("prio_det_a_rel", bus0.det_a, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    tick(1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1);
    checkOutput("prio_sa_cleanup", bus0.sa, 1'b0);

    // Glitch rejection on B: 3-cycle then 1-cycle pulse
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (3) begin
      tick(1);
      checkOutput("glitch_det_b", bus0.det_b, 1'b0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    tick(3);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    tick(1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (8) begin
      tick(1);
      checkOutput("glitch_det_b", bus0.det_b, 1'b0);
      checkOutput("glitch_sb", bus0.sb, 1'b0);
    end

    // A 4-cycle pulse is accepted
    for (int e = 1; e <= 12; e++) begin
      applyStimulus(1'b0, (e <= 4), 1'b0, 1'b0);
      tick(1);
      if (e == 5) checkOutput("p4_det_b_e5", bus0.det_b, 1'b0);
      if (e == 6) checkOutput("p4_det_b_e6", bus0.det_b, 1'b1);
      if (e == 7) checkOutput("p4_sb_e7", bus0.sb, 1'b1);
      if (e == 9) checkOutput("p4_det_b_e9", bus0.det_b, 1'b1);
      if (e == 10) checkOutput("p4_det_b_e10", bus0.det_b, 1'b0);
      if (e == 12) checkOutput("p4_sb_held", bus0.sb, 1'b1);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    tick(1);
    checkOutput("p4_sb_clr", bus0.sb, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1);

    // Latch and clear on B: 8-cycle press, green after 20 cycles
    for (int e = 1; e <= 20; e++) begin
      applyStimulus(1'b0, (e <= 8), 1'b0, 1'b0);
      tick(1);
      if (e == 6) checkOutput("latch_det_b_set", bus0.det_b, 1'b1);
      if (e == 7) checkOutput("latch_sb_set", bus0.sb, 1'b1);
      if (e == 14) checkOutput("latch_det_b_rel", bus0.det_b, 1'b0);
      if (e == 20) checkOutput("latch_sb_held", bus0.sb, 1'b1);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    tick(1);
    checkOutput("latch_sb_clr", bus0.sb, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) begin
      tick(1);
      checkOutput("latch_sb_stays", bus0.sb, 1'b0);
    end

    // Reset mid-operation: A requesting, B part-way through its count
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    tick(4);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    tick(4);
    checkOutput("mid_sa_pre", bus0.sa, 1'b1);
    checkOutput("mid_det_b_pre", bus0.det_b, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid_det_a_rst", bus0.det_a, 1'b0);
    checkOutput("mid_sa_rst", bus0.sa, 1'b0);
    checkOutput("mid_det_b_rst", bus0.det_b, 1'b0);
    checkOutput("mid_sb_rst", bus0.sb, 1'b0);
    #2 rst_n = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick(1);
      if (e == 6) begin
        checkOutput("mid_det_a_e6", bus0.det_a, 1'b1);
        checkOutput("mid_det_b_e6", bus0.det_b, 1'b1);
        checkOutput("mid_sa_e6", bus0.sa, 1'b0);
      end
      if (e == 7) begin
        checkOutput("mid_sa_e7", bus0.sa, 1'b1);
        checkOutput("mid_sb_e7", bus0.sb, 1'b1);
      end
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    tick(6);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    tick(1);
    checkOutput("both_grant_sa", bus0.sa, 1'b0);
    checkOutput("both_grant_sb", bus0.sb, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1);

    // DB_CYCLES=1: both roads together
    bus1.raw_a = 1'b1;
    bus1.raw_b = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      tick(1);
      if (e == 2) begin
        checkOutput("db1_det_a_e2", bus1.det_a, 1'b0);
        checkOutput("db1_det_b_e2", bus1.det_b, 1'b0);
      end
      if (e == 3) begin
        checkOutput("db1_det_a_e3", bus1.det_a, 1'b1);
        checkOutput("db1_det_b_e3", bus1.det_b, 1'b1);
        checkOutput("db1_sa_e3", bus1.sa, 1'b0);
      end
      if (e == 4) begin
        checkOutput("db1_sa_e4", bus1.sa, 1'b1);
        checkOutput("db1_sb_e4", bus1.sb, 1'b1);
      end
    end
    bus1.raw_a = 1'b0;
    bus1.raw_b = 1'b0;
    tick(3);
    checkOutput("db1_det_a_rel", bus1.det_a, 1'b0);
    bus1.ga = 1'b1;
    bus1.gb = 1'b1;
    tick(1);
    checkOutput("db1_sa_clr", bus1.sa, 1'b0);
    checkOutput("db1_sb_clr", bus1.sb, 1'b0);

    // Green held while a new detection arrives: request stays low
    bus1.gb    = 1'b0;
    bus1.raw_a = 1'b1;
    tick(4);
    checkOutput("db1_det_a_under_g", bus1.det_a, 1'b1);
    checkOutput("db1_sa_under_g", bus1.sa, 1'b0);
    bus1.ga = 1'b0;
    tick(1);
    checkOutput("db1_sa_after_g", bus1.sa, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
